// File: rtl/pcs_10g_hi_ber_fsm_if.sv
// Signal bundle between the sync-header checker, the hi-BER monitor and the PCS status stage.
// No valid/ready handshake: every input is sampled each clock and every output is a registered level.
interface pcs_10g_hi_ber_fsm_if;
  logic        block_lock;
  logic        sh_strobe;
  logic        sh_valid;
  logic        clr_cnt;
  logic        hi_ber;
  logic [5:0]  ber_cnt;
  logic [15:0] sh_invalid_cnt;
  logic [1:0]  ber_state;

  modport master (
    output block_lock, sh_strobe, sh_valid, clr_cnt,
    input  hi_ber, ber_cnt, sh_invalid_cnt, ber_state
  );

  modport slave (
    input  block_lock, sh_strobe, sh_valid, clr_cnt,
    output hi_ber, ber_cnt, sh_invalid_cnt, ber_state
  );
endinterface

// File: rtl/pcs_10g_hi_ber_fsm.sv
// 10GBASE-R receive BER monitor: counts invalid sync headers per fixed window and
// raises hi_ber when a window reaches the threshold; also keeps a saturating total.
module pcs_10g_hi_ber_fsm #(
  parameter int TIMER_CYCLES  = 80566,
  parameter int HI_BER_THRESH = 16
) (
  input logic               clk,
  input logic               rst_n,
  pcs_10g_hi_ber_fsm_if.slave bus
);

  localparam int TW = $clog2(TIMER_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_CYCLES - 1);
  localparam logic [5:0]    THRESH     = 6'(HI_BER_THRESH);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TEST   = 2'd1,
    ST_HI_BER = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          hi_ber_q, hi_ber_nxt;
  logic [5:0]    ber_cnt_q, ber_cnt_nxt;
  logic [15:0]   inv_cnt_q, inv_cnt_nxt;

  logic       bad;
  logic       counted;
  logic       timer_done;
  logic [6:0] cnt_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      timer_q   <= '0;
      hi_ber_q  <= 1'b0;
      ber_cnt_q <= '0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      hi_ber_q  <= hi_ber_nxt;
      ber_cnt_q <= ber_cnt_nxt;
      inv_cnt_q <= inv_cnt_nxt;
    end
  end

  always_comb begin
    bad         = bus.sh_strobe & ~bus.sh_valid & bus.block_lock;
    timer_done  = (timer_q == TIMER_LAST);
    cnt_sum     = {1'b0, ber_cnt_q} + {6'd0, bad};
    state_nxt   = state_q;
    timer_nxt   = timer_done ? '0 : timer_q + TW'(1);
    hi_ber_nxt  = hi_ber_q;
    ber_cnt_nxt = ber_cnt_q;

    case (state_q)
      ST_INIT: begin
        timer_nxt   = '0;
        hi_ber_nxt  = 1'b0;
        ber_cnt_nxt = '0;
        if (bus.block_lock) state_nxt = ST_TEST;
      end
      ST_TEST: begin
        // Threshold wins over the window end, so a bad header on timer_done still counts.
        if (cnt_sum >= {1'b0, THRESH}) begin
          state_nxt   = ST_HI_BER;
          hi_ber_nxt  = 1'b1;
          ber_cnt_nxt = THRESH;
        end else if (timer_done) begin
          hi_ber_nxt  = 1'b0;
          ber_cnt_nxt = '0;
        end else begin
          ber_cnt_nxt = cnt_sum[5:0];
        end
      end
      ST_HI_BER: begin
        ber_cnt_nxt = THRESH;
        if (timer_done) begin
          state_nxt   = ST_TEST;
          ber_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_INIT;
        timer_nxt   = '0;
        hi_ber_nxt  = 1'b0;
        ber_cnt_nxt = '0;
      end
    endcase

    if (!bus.block_lock) begin
      state_nxt   = ST_INIT;
      timer_nxt   = '0;
      hi_ber_nxt  = 1'b0;
      ber_cnt_nxt = '0;
    end

    // The cumulative count survives lock loss but ignores anything seen in INIT.
    counted     = bad & (state_q != ST_INIT);
    inv_cnt_nxt = inv_cnt_q;
    if (bus.clr_cnt) begin
      inv_cnt_nxt = {15'd0, counted};
    end else if (counted && (inv_cnt_q != 16'hFFFF)) begin
      inv_cnt_nxt = inv_cnt_q + 16'd1;
    end
  end

  assign bus.hi_ber         = hi_ber_q;
  assign bus.ber_cnt        = ber_cnt_q;
  assign bus.sh_invalid_cnt = inv_cnt_q;
  assign bus.ber_state      = state_q;

endmodule

// File: doc/pcs_10g_hi_ber_fsm.md
# pcs_10g_hi_ber_fsm

Receive-side high-BER detector for the 10GBASE-R PCS, implementing the Clause 49.2.13.2.3 BER monitor state machine (Figure 49-15). It sits between the block synchronizer / sync-header checker and the PCS status / BER monitor stage. It counts invalid 66-bit sync headers in fixed 125 µs windows and produces `hi_ber`, the per-window count and the cumulative `sh_invalid_cnt` that the status stage consumes.

## Interface
- TIMER_CYCLES, 80566, window length in `clk` cycles (125 µs at 644.53125 MHz); minimum 2.
- HI_BER_THRESH, 16, invalid headers per window that assert `hi_ber`; range 1..63.
- clk  input  1  PCS receive clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- block_lock  input  1  block synchronizer lock; low forces INIT.
- sh_strobe  input  1  qualifies `sh_valid` for one 66-bit block this cycle.
- sh_valid  input  1  1 = header 01/10; 0 = 00/11 (invalid). Ignored when `sh_strobe` = 0.
- clr_cnt  input  1  single-cycle pulse; clears `sh_invalid_cnt` (clear-on-read).
- hi_ber  output  1  high bit-error-rate indication.
- ber_cnt  output  6  invalid headers counted in the current window.
- sh_invalid_cnt  output  16  cumulative invalid-header count, saturating.
- ber_state  output  2  FSM state for debug: 0 INIT, 1 TEST, 2 HI_BER.

## Operation
- bad = `sh_strobe` & ~`sh_valid` & `block_lock`. Only strobed headers are evaluated.
- Window timer: width $clog2(TIMER_CYCLES).
  - Held at 0 in INIT.
  - In TEST/HI_BER, increments every cycle regardless of `sh_strobe`.
  - timer_done = (timer == TIMER_CYCLES-1). On that cycle the timer wraps to 0.
- INIT:
  - `hi_ber`=0, `ber_cnt`=0.
  - Leaves to TEST on the first cycle `block_lock`=1.
- TEST:
  - A bad header increments `ber_cnt`.
  - If `ber_cnt`+bad reaches HI_BER_THRESH: `hi_ber`<=1, state<=HI_BER, `ber_cnt`<=HI_BER_THRESH.
  - Else, on timer_done: `hi_ber`<=0 (GOOD_BER), `ber_cnt`<=0, stay in TEST.
  - The threshold check takes priority over timer_done. A bad header arriving on the timer_done cycle counts toward the closing window.
- HI_BER:
  - `ber_cnt` frozen at HI_BER_THRESH; further bad headers do not change it.
  - On timer_done: state<=TEST, `ber_cnt`<=0. `hi_ber` stays 1.
  - `hi_ber` clears only at the end of a later TEST window with fewer than HI_BER_THRESH bad headers. This gives a minimum high time of the remainder of the current window plus one full window.
- `block_lock`=0 in any state: next cycle state=INIT, `hi_ber`=0, `ber_cnt`=0, timer=0. `sh_invalid_cnt` is not affected.
- `sh_invalid_cnt`:
  - +1 on every bad header in any state except INIT; saturates at 0xFFFF.
  - `clr_cnt` clears it to 0.
  - `clr_cnt` and a bad header in the same cycle: result = 1.

## Timing
- Reset (`rst_n`=0 at a clock edge): state INIT, timer 0, `hi_ber`=0, `ber_cnt`=0, `sh_invalid_cnt`=0, `ber_state`=0.
- All outputs are registered. Each output reflects an input strobe one cycle after that strobe's edge.
- INIT -> TEST takes exactly 1 cycle after `block_lock` rises. The timer reads 0 in the first TEST cycle.
- `hi_ber` rise latency: 1 cycle after the cycle of the threshold-reaching bad header.
- `hi_ber` fall: 1 cycle after the qualifying timer_done cycle.
- Lock loss: 1-cycle latency to INIT values.
- Reset mid-window discards all state, including `sh_invalid_cnt`.
- No handshakes: inputs are sampled every cycle, outputs are level signals.

## Test plan
Run with TIMER_CYCLES=64 and HI_BER_THRESH=16 unless stated.
- Reset with `block_lock`=1, all-valid headers: every output is 0 during reset. `ber_state`=1 two cycles after reset release. `hi_ber` stays 0 for 1000 cycles.
- 15 bad headers spread in one window: `ber_cnt` reads 15 and `hi_ber` stays 0. `ber_cnt`=0 one cycle after timer_done. `sh_invalid_cnt`=15.
- 16 bad headers in window 1, then a clean window 2:
  - `hi_ber`=1 and `ber_state`=2 one cycle after the 16th bad header.
  - `ber_state`=1 after window 1 ends; `hi_ber` still 1.
  - `hi_ber`=0 one cycle after window 2's timer_done.
- 16th bad header lands exactly on the timer_done cycle: `hi_ber` asserts and `ber_cnt`=16. The next window then starts in HI_BER-exit flow as above.
- Drop `block_lock` while `hi_ber`=1: next cycle `hi_ber`=0, `ber_cnt`=0, `ber_state`=0, `sh_invalid_cnt` unchanged. Bad headers while unlocked are not counted.
- Counter edges:
  - 65540 bad headers: `sh_invalid_cnt` holds at 0xFFFF.
  - `clr_cnt` coincident with a bad header: `sh_invalid_cnt`=1.
  - `sh_strobe`=0 with `sh_valid`=0: no count changes.
